// File: rtl/mdu_hilo_unit.sv
// Multiply/divide unit that owns HI/LO: multi-cycle MULT/DIV and multiply-accumulate ops,
// MTHI/MTLO writes, and the EX-stage stall when an op or HI/LO reader meets a running op.
module mdu_hilo_unit #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 2,
   parameter int DIV_BITS   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             hilo_read_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             stall_o
);

   localparam int DIV_STEPS = WIDTH / DIV_BITS;
   localparam int CNT_MAX   = (MUL_CYCLES > DIV_STEPS) ? MUL_CYCLES : DIV_STEPS;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int PW        = 2 * WIDTH + 2;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MADD  = 4'd5;
   localparam logic [3:0] OP_MADDU = 4'd6;
   localparam logic [3:0] OP_MSUB  = 4'd7;
   localparam logic [3:0] OP_MSUBU = 4'd8;
   localparam logic [3:0] OP_MTHI  = 4'd9;
   localparam logic [3:0] OP_MTLO  = 4'd10;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      cond_neg = neg ? -v : v;
   endfunction

   function automatic logic is_signed_op(input logic [3:0] op);
      is_signed_op = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

   logic accept;
   assign accept = valid_i & ~flush_i & (state_q == S_IDLE);

   // Multiplier: operands extended by one bit so one signed multiply serves both signednesses.
   logic                    mul_sgn;
   logic signed [PW-1:0]    mul_a_s, mul_b_s, prod_s;
   logic [2*WIDTH-1:0]      prod, hilo_cur, mul_res;

   assign mul_sgn  = is_signed_op(op_q);
   assign mul_a_s  = {{(PW-WIDTH){mul_sgn & a_q[WIDTH-1]}}, a_q};
   assign mul_b_s  = {{(PW-WIDTH){mul_sgn & b_q[WIDTH-1]}}, b_q};
   assign prod_s   = mul_a_s * mul_b_s;
   assign prod     = prod_s[2*WIDTH-1:0];
   assign hilo_cur = {hi_q, lo_q};

   always_comb begin
      mul_res = prod;
      case (op_q)
         OP_MADD, OP_MADDU: mul_res = hilo_cur + prod;
         OP_MSUB, OP_MSUBU: mul_res = hilo_cur - prod;
         default:           mul_res = prod;
      endcase
   end

   // Restoring divider on magnitudes; quo_q doubles as the dividend shift register.
   logic [WIDTH-1:0] quo_step, rem_step;
   logic [WIDTH:0]   rem_sh;

   always_comb begin
      quo_step = quo_q;
      rem_step = rem_q;
      rem_sh   = '0;
      for (int i = 0; i < DIV_BITS; i++) begin
         rem_sh   = {rem_step, quo_step[WIDTH-1]};
         quo_step = {quo_step[WIDTH-2:0], 1'b0};
         if (rem_sh >= {1'b0, dvs_q}) begin
            rem_sh      = rem_sh - {1'b0, dvs_q};
            quo_step[0] = 1'b1;
         end
         rem_step = rem_sh[WIDTH-1:0];
      end
   end

   // Sign fix-up; min/-1 needs no special case since |min| fits unsigned and the signs cancel.
   logic             div_sgn, q_neg, r_neg, dbz;
   logic [WIDTH-1:0] fix_hi, fix_lo;

   assign div_sgn = (op_q == OP_DIV);
   assign q_neg   = div_sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
   assign r_neg   = div_sgn & a_q[WIDTH-1];
   assign dbz     = (b_q == '0);
   assign fix_hi  = dbz ? a_q : cond_neg(rem_q, r_neg);
   assign fix_lo  = dbz ? '1  : cond_neg(quo_q, q_neg);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (op_i)
                  OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                     state_d = S_MUL;
                     cnt_d   = CNT_W'(MUL_CYCLES - 1);
                     op_d    = op_i;
                     a_d     = src_a;
                     b_d     = src_b;
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d = S_DIV;
                     cnt_d   = CNT_W'(DIV_STEPS - 1);
                     op_d    = op_i;
                     a_d     = src_a;
                     b_d     = src_b;
                     quo_d   = cond_neg(src_a, is_signed_op(op_i) & src_a[WIDTH-1]);
                     dvs_d   = cond_neg(src_b, is_signed_op(op_i) & src_b[WIDTH-1]);
                     rem_d   = '0;
                  end
                  OP_MTHI: hi_d = src_a;
                  OP_MTLO: lo_d = src_a;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               {hi_d, lo_d} = mul_res;
               done_d       = 1'b1;
               state_d      = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DIV: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               quo_d = quo_step;
               rem_d = rem_step;
               if (cnt_q == '0) state_d = S_FIX;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!flush_i) begin
               hi_d   = fix_hi;
               lo_d   = fix_lo;
               done_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign hi_o    = hi_q;
   assign lo_o    = lo_q;
   assign busy_o  = (state_q != S_IDLE);
   assign done_o  = done_q;
   assign stall_o = ~flush_i & busy_o &
                    ((valid_i & (op_i >= OP_MULT) & (op_i <= OP_MTLO)) | hilo_read_i);

endmodule
